// File: rtl/ahb_sram_slave_param_if.sv
// AHB-Lite bus bundle between a master/decoder and the SRAM slave.
// Clock and reset stay outside the bundle as plain ports.
interface ahb_sram_slave_param_if #(
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [1:0]        htrans;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [31:0]       haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready_in;
  logic              hready_out;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, htrans, hburst, hsize, hwrite, haddr, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hburst, hsize, hwrite, haddr, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave_param.sv
// AHB-Lite SRAM slave: byte-lane writes through a one-entry pending-write
// register, read-after-write forwarding, optional read wait states and a
// two-cycle ERROR response for out-of-range / badly sized transfers.
module ahb_sram_slave_param #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_8000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                    hclk,
  input  logic                    hrst,
  ahb_sram_slave_param_if.slave   bus
);
  localparam int NB  = DATA_W / 8;
  localparam int BL  = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int AHI = IW + BL;

  typedef enum logic [1:0] {IDLE, RD_WAIT, ERR1, ERR2} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic              rdy, busy_err;
  logic [1:0]        resp;

  // address-phase decode
  logic              accept, a_legal, size_ok, aligned, in_range;
  logic [IW-1:0]     a_idx;
  logic [BL-1:0]     a_lo;
  logic [NB-1:0]     a_mask;
  int                nbytes;

  // registered data-phase write info
  logic              dp_wr;
  logic [IW-1:0]     dp_idx;
  logic [NB-1:0]     dp_mask;

  // pending write awaiting commit to the array
  logic              pw_vld;
  logic [IW-1:0]     pw_idx;
  logic [NB-1:0]     pw_mask, pw_mask_nxt;
  logic [DATA_W-1:0] pw_data, pw_data_nxt;
  logic              same_word, commit;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] fwd;
  logic [DATA_W-1:0] rdata_q;

  assign accept = bus.hsel & bus.hready_in & bus.htrans[1];
  assign a_idx  = bus.haddr[AHI-1:BL];
  assign a_lo   = bus.haddr[BL-1:0];

  // Legality check and little-endian byte-lane mask for the address phase
  always_comb begin
    nbytes   = 1 << bus.hsize;
    size_ok  = (bus.hsize <= 3'(BL));
    aligned  = ((int'(a_lo) & (nbytes - 1)) == 0);
    in_range = (bus.haddr[31:AHI] == BASE_ADDR[31:AHI]);
    a_legal  = size_ok & aligned & in_range;
    a_mask   = '0;
    for (int k = 0; k < NB; k++)
      a_mask[k] = (k >= int'(a_lo)) && (k < int'(a_lo) + nbytes);
  end

  // Read word with the pending write and the write currently in its data
  // phase overlaid, newest last, so back-to-back write->read sees its data
  always_comb begin
    fwd = mem[a_idx];
    for (int k = 0; k < NB; k++) begin
      if (pw_vld && pw_idx == a_idx && pw_mask[k]) fwd[8*k +: 8] = pw_data[8*k +: 8];
      if (dp_wr && dp_idx == a_idx && dp_mask[k])  fwd[8*k +: 8] = bus.hwdata[8*k +: 8];
    end
  end

  // Merge a new write into the pending entry when it targets the same word
  always_comb begin
    same_word   = pw_vld && dp_wr && (pw_idx == dp_idx);
    commit      = pw_vld && !same_word;
    pw_data_nxt = same_word ? pw_data : '0;
    pw_mask_nxt = (same_word ? pw_mask : '0) | dp_mask;
    for (int k = 0; k < NB; k++)
      if (dp_mask[k]) pw_data_nxt[8*k +: 8] = bus.hwdata[8*k +: 8];
  end

  // Next state and data-phase response
  always_comb begin
    state_nxt = IDLE;
    rdy       = 1'b1;
    busy_err  = 1'b0;
    case (state)
      ERR1:    begin rdy = 1'b0; busy_err = 1'b1; state_nxt = ERR2; end
      RD_WAIT: begin rdy = (cnt == 3'd0); if (cnt != 3'd0) state_nxt = RD_WAIT; end
      ERR2:    busy_err = 1'b1;
      default: ;
    endcase
    if (rdy && accept) begin
      if (!a_legal)                               state_nxt = ERR1;
      else if (!bus.hwrite && WAIT_STATES > 0)    state_nxt = RD_WAIT;
    end
    resp = busy_err ? 2'b01 : 2'b00;
  end

  assign bus.hready_out = rdy;
  assign bus.hresp      = resp;
  assign bus.hrdata     = rdata_q;

  // FSM, wait counter, data-phase capture, pending write and read data
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state   <= IDLE;
      cnt     <= '0;
      dp_wr   <= 1'b0;
      dp_idx  <= '0;
      dp_mask <= '0;
      pw_vld  <= 1'b0;
      pw_idx  <= '0;
      pw_mask <= '0;
      pw_data <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == RD_WAIT && state != RD_WAIT)
        cnt <= 3'(WAIT_STATES);
      else if (state == RD_WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      dp_wr <= rdy && accept && a_legal && bus.hwrite;
      if (rdy && accept) begin
        dp_idx  <= a_idx;
        dp_mask <= a_mask;
      end
      pw_vld <= dp_wr;
      if (dp_wr) begin
        pw_idx  <= dp_idx;
        pw_mask <= pw_mask_nxt;
        pw_data <= pw_data_nxt;
      end
      if (rdy && accept && a_legal && !bus.hwrite)
        rdata_q <= fwd;
    end
  end

  // Array update from the pending write; contents are never reset
  always_ff @(posedge hclk) begin
    if (commit)
      for (int k = 0; k < NB; k++)
        if (pw_mask[k]) mem[pw_idx][8*k +: 8] <= pw_data[8*k +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_slave_param.sv
// Directed bench: a zero-wait instance and a three-wait instance share one
// stimulus set; hsel is steered to the target under test.
module tb_ahb_sram_slave_param;
  localparam logic [31:0] B = 32'hFFFF_8000;

  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic        tgt  = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hburst = 3'b000;
  logic [2:0]  hsize  = 3'b010;
  logic        hwrite = 1'b0;
  logic [31:0] haddr  = '0;
  logic [31:0] hwdata = '0;

  int ntests = 0;
  int nfail  = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave_param_if #(.DATA_W(32)) b0 ();
  ahb_sram_slave_param_if #(.DATA_W(32)) b1 ();

  assign b0.hsel = hsel & ~tgt;
  assign b1.hsel = hsel & tgt;
  assign b0.htrans = htrans;  assign b1.htrans = htrans;
  assign b0.hburst = hburst;  assign b1.hburst = hburst;
  assign b0.hsize  = hsize;   assign b1.hsize  = hsize;
  assign b0.hwrite = hwrite;  assign b1.hwrite = hwrite;
  assign b0.haddr  = haddr;   assign b1.haddr  = haddr;
  assign b0.hwdata = hwdata;  assign b1.hwdata = hwdata;
  assign b0.hready_in = b0.hready_out;
  assign b1.hready_in = b1.hready_out;

  wire        rdy   = tgt ? b1.hready_out : b0.hready_out;
  wire [1:0]  resp  = tgt ? b1.hresp      : b0.hresp;
  wire [31:0] rdata = tgt ? b1.hrdata     : b0.hrdata;

  ahb_sram_slave_param #(.DATA_W(32), .DEPTH(1024), .BASE_ADDR(B), .WAIT_STATES(0))
    dut0 (.hclk(hclk), .hrst(hrst), .bus(b0));
  ahb_sram_slave_param #(.DATA_W(32), .DEPTH(1024), .BASE_ADDR(B), .WAIT_STATES(3))
    dut3 (.hclk(hclk), .hrst(hrst), .bus(b1));

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp, input logic err);
    vec_t v;
    v.wr = wr; v.sz = sz; v.addr = addr; v.wdata = wdata; v.exp = exp; v.err = err;
    tbl.push_back(v);
  endfunction

  // One non-pipelined transfer: address phase, then data phase until ready
  task automatic single(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic [1:0] rsp,
                        output int waits, output logic err_low, output logic done);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = addr;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = wdata;
    waits = 0; err_low = 1'b0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge hclk);
      if (rdy) begin done = 1'b1; break; end
      waits++;
      if (resp == 2'b01) err_low = 1'b1;
      @(posedge hclk); #1;
    end
    rd = rdata; rsp = resp;
    @(posedge hclk); #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  int          waits;
  logic        err_low, done;

  initial begin
    // reset state
    #12;
    @(negedge hclk);
    for (int t = 0; t < 2; t++) begin
      tgt = t[0];
      #0;
      chk($sformatf("rst_ready%0d", t), {31'd0, rdy}, 32'd1);
      chk($sformatf("rst_resp%0d", t),  {30'd0, resp}, 32'd0);
      chk($sformatf("rst_rdata%0d", t), rdata, 32'd0);
    end
    tgt = 1'b0;
    hrst = 1'b0;
    @(posedge hclk); #1;

    // table on the zero-wait instance
    for (int i = 1; i <= 11; i++) add(1'b1, 3'd2, B + 32'(4*i), 32'h8000_0000 + 32'(i), '0, 1'b0);
    for (int i = 1; i <= 11; i++) add(1'b0, 3'd2, B + 32'(4*i), '0, 32'h8000_0000 + 32'(i), 1'b0);
    add(1'b1, 3'd2, B,              32'h1234_5678, '0, 1'b0);
    add(1'b1, 3'd2, B + 32'h1000,   32'hBAD0_BAD0, '0, 1'b1);  // one past the end
    add(1'b0, 3'd2, B,              '0, 32'h1234_5678, 1'b0);  // untouched by illegal write
    add(1'b0, 3'd1, B + 32'h1,      '0, '0, 1'b1);             // misaligned half
    add(1'b0, 3'd3, B,              '0, '0, 1'b1);             // dword on 32-bit bus
    add(1'b0, 3'd2, B - 32'h4,      '0, '0, 1'b1);             // below base
    add(1'b1, 3'd1, B + 32'h2,      32'hABCD_0000, '0, 1'b0);  // upper half lanes
    add(1'b0, 3'd2, B,              '0, 32'hABCD_5678, 1'b0);
    add(1'b1, 3'd2, B + 32'hFFC,    32'hDEAD_BEEF, '0, 1'b0);  // last word
    add(1'b0, 3'd2, B + 32'hFFC,    '0, 32'hDEAD_BEEF, 1'b0);
    add(1'b0, 3'd0, B + 32'hFFF,    '0, 32'hDEAD_BEEF, 1'b0);  // byte read returns full word

    foreach (tbl[i]) begin
      single(tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wdata, rd, rsp, waits, err_low, done);
      chk($sformatf("v%0d_done", i),  {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_resp", i),  {30'd0, rsp},  tbl[i].err ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_waits", i), 32'(waits),    tbl[i].err ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_errlo", i), {31'd0, err_low}, {31'd0, tbl[i].err});
      if (!tbl[i].wr && !tbl[i].err) chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp);
    end

    // back-to-back byte write then read of the same word (forwarding)
    hburst = 3'b001;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0; haddr = B + 32'h9;
    @(posedge hclk); #1;
    htrans = 2'b11; hwrite = 1'b0; hsize = 3'd2; haddr = B + 32'h8; hwdata = 32'h0000_A500;
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    chk("fwd_ready", {31'd0, rdy}, 32'd1);
    chk("fwd_resp",  {30'd0, resp}, 32'd0);
    chk("fwd_rdata", rdata, 32'h8000_A502);
    @(posedge hclk); #1;
    single(1'b0, 3'd2, B + 32'h8, '0, rd, rsp, waits, err_low, done);
    chk("fwd_commit_rdata", rd, 32'h8000_A502);
    hburst = 3'b000;

    // three wait states on the second instance
    tgt = 1'b1;
    single(1'b1, 3'd2, B, 32'hCAFE_0000, rd, rsp, waits, err_low, done);
    chk("ws_wr_waits", 32'(waits), 32'd0);
    single(1'b0, 3'd2, B, '0, rd, rsp, waits, err_low, done);
    chk("ws_rd_done",  {31'd0, done}, 32'd1);
    chk("ws_rd_waits", 32'(waits), 32'd3);
    chk("ws_rd_resp",  {30'd0, rsp}, 32'd0);
    chk("ws_rd_rdata", rd, 32'hCAFE_0000);

    // reset while a read waits and a write is still pending
    single(1'b1, 3'd2, B + 32'h10, 32'h1111_1111, rd, rsp, waits, err_low, done);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = B + 32'h10;
    @(posedge hclk); #1;
    hwrite = 1'b0; haddr = B + 32'h20; hwdata = 32'h2222_2222;
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    chk("rst_mid_waiting", {31'd0, rdy}, 32'd0);
    #1 hrst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, rdy}, 32'd1);
    chk("rst_mid_resp",  {30'd0, resp}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    @(negedge hclk);
    hrst = 1'b0;
    @(posedge hclk); #1;
    single(1'b0, 3'd2, B + 32'h10, '0, rd, rsp, waits, err_low, done);
    chk("rst_drop_waits", 32'(waits), 32'd3);
    chk("rst_drop_rdata", rd, 32'h1111_1111);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
